// File: rtl/rv32i_lsu_sequencer_if.sv
// rv32i_lsu_sequencer_if: request/response handshake plus RAM data-port bundle.
// master is the execute stage and RAM side; slave is the sequencer.
interface rv32i_lsu_sequencer_if;
   logic        req_valid, req_ready, req_we, req_sign;
   logic [1:0]  req_width;
   logic [31:0] req_addr, req_wdata;
   logic [29:0] d_addr;
   logic        d_we;
   logic [3:0]  d_be;
   logic [31:0] d_wdata, d_rdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   modport master (
      output req_valid, req_we, req_width, req_sign, req_addr, req_wdata, d_rdata,
      input  req_ready, d_addr, d_we, d_be, d_wdata, resp_valid, resp_rdata, resp_err
   );
   modport slave (
      input  req_valid, req_we, req_width, req_sign, req_addr, req_wdata, d_rdata,
      output req_ready, d_addr, d_we, d_be, d_wdata, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/rv32i_lsu_sequencer.sv
// rv32i_lsu_sequencer: one-at-a-time load/store sequencer that splits misaligned
// accesses into two word beats and merges/extends returned load data.
module rv32i_lsu_sequencer (
   input logic clk,
   input logic reset,
   rv32i_lsu_sequencer_if.slave bus
);
   localparam logic [2:0] IDLE = 3'd0, BEAT0 = 3'd1, BEAT1 = 3'd2, WAIT = 3'd3, RESP = 3'd4;
   logic [2:0]  state, nxt;
   logic        we_q, sign_q;
   logic [1:0]  width_q;
   logic [31:0] addr_q, wdata_q, lo_q;
   logic [29:0] d_addr;
   logic        d_we, resp_valid, resp_err;
   logic [3:0]  d_be;
   logic [31:0] d_wdata, resp_rdata;
   logic        idle, accept, we, mis;
   logic [1:0]  width, off;
   logic [31:0] addr, m, ext;
   logic [3:0]  mask;
   logic [7:0]  be8;
   logic [63:0] wd64;
   // In IDLE the live request drives the first beat; afterwards the latched copy does.
   always_comb begin
      idle   = state == IDLE;
      accept = idle && bus.req_valid;
      we     = idle ? bus.req_we : we_q;
      width  = idle ? bus.req_width : width_q;
      addr   = idle ? bus.req_addr : addr_q;
      off    = addr[1:0];
      mask   = width == 2'b00 ? 4'b0001 : width == 2'b01 ? 4'b0011 : 4'b1111;
      be8    = {4'b0000, mask} << off;
      mis    = |be8[7:4];
      wd64   = {32'b0, idle ? bus.req_wdata : wdata_q} << {off, 3'b000};
      m      = 32'({bus.d_rdata, mis ? lo_q : bus.d_rdata} >> {off, 3'b000});
      ext    = width_q == 2'b00 ? {{24{sign_q & m[7]}}, m[7:0]}
             : width_q == 2'b01 ? {{16{sign_q & m[15]}}, m[15:0]} : m;
      nxt    = state == IDLE  ? (accept ? (width == 2'b11 ? RESP : BEAT0) : IDLE)
             : state == BEAT0 ? (mis ? BEAT1 : we ? RESP : WAIT)
             : state == BEAT1 ? (we ? RESP : WAIT)
             : state == WAIT  ? RESP : IDLE;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         we_q       <= 1'b0;
         sign_q     <= 1'b0;
         width_q    <= 2'b00;
         addr_q     <= 32'b0;
         wdata_q    <= 32'b0;
         lo_q       <= 32'b0;
         d_addr     <= 30'b0;
         d_we       <= 1'b0;
         d_be       <= 4'b0;
         d_wdata    <= 32'b0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'b0;
      end else begin
         state <= nxt;
         if (accept) begin
            we_q    <= bus.req_we;
            sign_q  <= bus.req_sign;
            width_q <= bus.req_width;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
         end
         if (state == BEAT1) lo_q <= bus.d_rdata;
         if (nxt == BEAT0 || nxt == BEAT1) begin
            d_addr  <= nxt == BEAT0 ? addr[31:2] : addr[31:2] + 30'd1;
            d_wdata <= nxt == BEAT0 ? wd64[31:0] : wd64[63:32];
         end
         d_we       <= (nxt == BEAT0 || nxt == BEAT1) && we;
         d_be       <= !we ? 4'b0 : nxt == BEAT0 ? be8[3:0] : nxt == BEAT1 ? be8[7:4] : 4'b0;
         resp_valid <= nxt == RESP;
         if (nxt == RESP) begin
            resp_err   <= idle;
            resp_rdata <= state == WAIT ? ext : 32'b0;
         end
      end
   end
   assign bus.req_ready  = idle;
   assign bus.d_addr     = d_addr;
   assign bus.d_we       = d_we;
   assign bus.d_be       = d_be;
   assign bus.d_wdata    = d_wdata;
   assign bus.resp_valid = resp_valid;
   assign bus.resp_err   = resp_err;
   assign bus.resp_rdata = resp_rdata;
endmodule

// File: tb/tb_rv32i_lsu_sequencer.sv
// tb_rv32i_lsu_sequencer: directed scoreboard bench with a byte-lane RAM model.
module tb_rv32i_lsu_sequencer;
   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic [31:0] lat;
      logic [31:0] acc;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   rv32i_lsu_sequencer_if bus ();
   rv32i_lsu_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   logic [31:0] mem [256];
   int cyc = 0;
   int n_cmp = 0, n_bad = 0, n_resp = 0;
   int last_resp = 0, acc_cyc = 0;
   logic accepted = 1'b0;
   exp_t nxt_exp, sb[$];
   string cur_tag, tq[$];
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      if (bus.d_we)
         for (int i = 0; i < 4; i++)
            if (bus.d_be[i]) mem[bus.d_addr[7:0]][8*i +: 8] = bus.d_wdata[8*i +: 8];
      bus.d_rdata <= mem[bus.d_addr[7:0]];
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      exp_t e;
      string t;
      @(negedge clk);
      if (bus.resp_valid) begin
         n_resp++;
         last_resp = cyc;
         n_cmp++;
         assert (sb.size() != 0) else begin
            n_bad++;
            $error("FAIL unexpected_resp: observed resp_valid=1 at cycle %0d expected none", cyc);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            t = tq.pop_front();
            chk({t, "_rdata"}, bus.resp_rdata, e.rdata);
            chk({t, "_err"}, {31'b0, bus.resp_err}, {31'b0, e.err});
            chk({t, "_latency"}, 32'(cyc) - e.acc, e.lat);
         end
      end
      accepted = 1'b0;
      if (bus.req_valid && bus.req_ready) begin
         e = nxt_exp;
         e.acc = 32'(cyc);
         sb.push_back(e);
         tq.push_back(cur_tag);
         accepted = 1'b1;
         acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
   endtask
   task automatic send(input string tag, input logic we, input logic [1:0] w, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic er, input int lat, input logic hold);
      bus.req_we    = we;
      bus.req_width = w;
      bus.req_sign  = sg;
      bus.req_addr  = a;
      bus.req_wdata = wd;
      bus.req_valid = 1'b1;
      nxt_exp.rdata = exp_rd;
      nxt_exp.err   = er;
      nxt_exp.lat   = 32'(lat);
      nxt_exp.acc   = 32'b0;
      cur_tag       = tag;
      accepted      = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (accepted) break;
      end
      chk({tag, "_accepted"}, {31'b0, accepted}, 32'd1);
      if (!hold) bus.req_valid = 1'b0;
   endtask
   task automatic drain(input string tag);
      for (int i = 0; i < 12 && sb.size() != 0; i++) tick();
      chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
   endtask
   task automatic chk_beat(input string tag, input logic [29:0] a, input logic [3:0] be,
                           input logic [31:0] wd, input logic we);
      chk({tag, "_d_addr"}, {2'b0, bus.d_addr}, {2'b0, a});
      chk({tag, "_d_be"}, {28'b0, bus.d_be}, {28'b0, be});
      chk({tag, "_d_wdata"}, bus.d_wdata, wd);
      chk({tag, "_d_we"}, {31'b0, bus.d_we}, {31'b0, we});
   endtask
   initial begin
      int n0;
      for (int i = 0; i < 256; i++) mem[i] = 32'b0;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_width = 2'b00;
      bus.req_sign  = 1'b0;
      bus.req_addr  = 32'b0;
      bus.req_wdata = 32'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
      chk_beat("rst", 30'h0, 4'h0, 32'h0, 1'b0);
      chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
      chk("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      // aligned byte store, then signed and unsigned byte loads
      send("st_b", 1'b1, 2'b00, 1'b0, 32'h50, 32'h80, 32'h0, 1'b0, 2, 1'b0);
      chk_beat("st_b_beat0", 30'h14, 4'b0001, 32'h80, 1'b1);
      drain("st_b");
      send("ld_bs", 1'b0, 2'b00, 1'b1, 32'h50, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1'b0);
      chk_beat("ld_bs_beat0", 30'h14, 4'b0000, 32'h0, 1'b0);
      drain("ld_bs");
      send("ld_bu", 1'b0, 2'b00, 1'b0, 32'h50, 32'h0, 32'h00000080, 1'b0, 3, 1'b0);
      drain("ld_bu");
      // misaligned word store/load
      send("st_wm", 1'b1, 2'b10, 1'b0, 32'h56, 32'h12345678, 32'h0, 1'b0, 3, 1'b0);
      chk_beat("st_wm_beat0", 30'h15, 4'b1100, 32'h56780000, 1'b1);
      tick();
      chk_beat("st_wm_beat1", 30'h16, 4'b0011, 32'h00001234, 1'b1);
      drain("st_wm");
      send("ld_wm", 1'b0, 2'b10, 1'b0, 32'h56, 32'h0, 32'h12345678, 1'b0, 4, 1'b0);
      drain("ld_wm");
      // halfword store and loads
      send("st_h", 1'b1, 2'b01, 1'b0, 32'h60, 32'hFFFB, 32'h0, 1'b0, 2, 1'b0);
      chk_beat("st_h_beat0", 30'h18, 4'b0011, 32'h0000FFFB, 1'b1);
      drain("st_h");
      send("ld_hs", 1'b0, 2'b01, 1'b1, 32'h60, 32'h0, 32'hFFFFFFFB, 1'b0, 3, 1'b0);
      drain("ld_hs");
      send("ld_hu", 1'b0, 2'b01, 1'b0, 32'h60, 32'h0, 32'h0000FFFB, 1'b0, 3, 1'b0);
      drain("ld_hu");
      // halfword straddling the top of the address space
      send("st_hw", 1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'hA55A, 32'h0, 1'b0, 3, 1'b0);
      chk_beat("st_hw_beat0", 30'h3FFFFFFF, 4'b1000, 32'h5A000000, 1'b1);
      tick();
      chk_beat("st_hw_beat1", 30'h0, 4'b0001, 32'h000000A5, 1'b1);
      drain("st_hw");
      send("ld_hw", 1'b0, 2'b01, 1'b1, 32'hFFFFFFFF, 32'h0, 32'hFFFFA55A, 1'b0, 4, 1'b0);
      drain("ld_hw");
      // illegal width: error response, no RAM write
      send("ill_st", 1'b1, 2'b11, 1'b0, 32'h50, 32'hDEADBEEF, 32'h0, 1'b1, 1, 1'b0);
      chk("ill_st_d_we", {31'b0, bus.d_we}, 32'd0);
      drain("ill_st");
      send("ill_ld", 1'b0, 2'b11, 1'b1, 32'h56, 32'h0, 32'h0, 1'b1, 1, 1'b0);
      drain("ill_ld");
      send("ld_bu2", 1'b0, 2'b00, 1'b0, 32'h50, 32'h0, 32'h00000080, 1'b0, 3, 1'b0);
      drain("ld_bu2");
      // reset during BEAT1 of a misaligned store
      send("st_rst", 1'b1, 2'b10, 1'b0, 32'h81, 32'hCAFEF00D, 32'h0, 1'b0, 3, 1'b0);
      tick();
      chk("st_rst_beat1_we", {31'b0, bus.d_we}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("st_rst_async_we", {31'b0, bus.d_we}, 32'd0);
      chk("st_rst_async_be", {28'b0, bus.d_be}, 32'd0);
      chk("st_rst_async_rv", {31'b0, bus.resp_valid}, 32'd0);
      sb.delete();
      tq.delete();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      n0 = n_resp;
      repeat (4) tick();
      chk("post_rst_no_resp", 32'(n_resp - n0), 32'd0);
      chk("post_rst_ready", {31'b0, bus.req_ready}, 32'd1);
      send("ld_wm2", 1'b0, 2'b10, 1'b0, 32'h56, 32'h0, 32'h12345678, 1'b0, 4, 1'b0);
      drain("ld_wm2");
      // back-to-back with req_valid held high
      n0 = n_resp;
      send("b2b_0", 1'b0, 2'b01, 1'b0, 32'h60, 32'h0, 32'h0000FFFB, 1'b0, 3, 1'b1);
      send("b2b_1", 1'b1, 2'b10, 1'b0, 32'h70, 32'h0BADBEEF, 32'h0, 1'b0, 2, 1'b1);
      chk("b2b_1_gap", 32'(acc_cyc - last_resp), 32'd1);
      send("b2b_2", 1'b0, 2'b10, 1'b0, 32'h70, 32'h0, 32'h0BADBEEF, 1'b0, 3, 1'b0);
      chk("b2b_2_gap", 32'(acc_cyc - last_resp), 32'd1);
      drain("b2b");
      repeat (3) tick();
      chk("b2b_resp_count", 32'(n_resp - n0), 32'd3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end
endmodule

// File: doc/rv32i_lsu_sequencer.md
# rv32i_lsu_sequencer

Load/store sequencer between the execute stage and the data port of `rv32i_syncDualPortRam`. It accepts one memory request at a time over a valid/ready handshake and drives registered word address, byte-enable and lane-shifted write data. It splits misaligned accesses into two word beats, then merges, shifts and sign- or zero-extends load data before returning a one-cycle response.

## Interface
- No parameters. The RAM word address is fixed at 30 bits (byte address [31:2]).
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: high only in IDLE.
- `req_we` input 1: 1 = store, 0 = load.
- `req_width` input 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_sign` input 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-justified.
- `d_addr` output 30: RAM word address.
- `d_we` output 1: RAM write enable.
- `d_be` output 4: RAM byte enables; bit n enables byte lane n.
- `d_wdata` output 32: lane-aligned write data.
- `d_rdata` input 32: RAM read data, valid the cycle after `d_addr` is presented.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output 32: extended load data; 0 for stores and errors.
- `resp_err` output 1: illegal width; valid with `resp_valid`.

## Operation
- Accept occurs when `req_valid && req_ready`. All request fields are latched at accept. Fields are ignored while not ready.
- States: IDLE, BEAT0, BEAT1, WAIT, RESP.
  - IDLE: on accept, go to RESP if width is 11, otherwise go to BEAT0.
  - BEAT0: go to BEAT1 if misaligned. Otherwise go to WAIT for loads, RESP for stores.
  - BEAT1: go to WAIT for loads, RESP for stores.
  - WAIT: go to RESP.
  - RESP: go to IDLE.
- Let off = addr[1:0] and mask = 0001 / 0011 / 1111 for byte / half / word. An access is misaligned when (mask << off) exceeds 4 bits: half at off 3, word at off 1–3.
- BEAT0 drives:
  - `d_addr` = addr[31:2]
  - `d_be` = (mask << off)[3:0]
  - `d_wdata` = wdata << 8·off
- BEAT1 drives:
  - `d_addr` = addr[31:2]+1, modulo 2^30 (wraps 0x3FFFFFFF → 0)
  - `d_be` = (mask << off)[7:4]
  - `d_wdata` = wdata >> 8·(4−off)
- `d_we` = `req_we` during BEAT0/BEAT1, else 0. `d_be` = 0 for loads and in every other state.
- Load capture: the low word is captured on the edge ending the cycle after BEAT0, the high word one cycle after BEAT1.
- Load assembly: {hi, lo} >> 8·off, truncated to width, then extended per `req_sign`.
- Illegal width: no RAM beat issued, `resp_err` = 1, `resp_rdata` = 0.
- Reset mid-operation: the request is abandoned and no response is issued. All outputs drop to reset values immediately.

## Timing
- Reset values: state IDLE, `req_ready` 1, `d_addr` 0, `d_we` 0, `d_be` 0, `d_wdata` 0, `resp_valid` 0, `resp_rdata` 0, `resp_err` 0.
- All RAM-side and response outputs are registered; `req_ready` is decoded from state.
- With T as the accept cycle, `resp_valid` is high during:
  - T+3 for an aligned load
  - T+4 for a misaligned load
  - T+2 for an aligned store
  - T+3 for a misaligned store
  - T+1 for an illegal width
- Next accept is possible in the cycle after RESP.
- `resp_rdata` / `resp_err` are valid only while `resp_valid` is high; they hold their last value otherwise.
- The RAM samples `d_*` at the end of each BEAT cycle; a store's last beat commits before its `resp_valid`.
- `req_valid` high in a non-IDLE state causes no state change and no latch.

## Test plan
- Aligned byte store/load: store width 00, addr 0x50, wdata 0x80 → T+1: `d_addr` 0x14, `d_be` 0001, `d_we` 1, `d_wdata` 0x80; ack at T+2. Then signed byte load at 0x50 → `resp_rdata` 0xFFFFFF80 at T+3; unsigned load → 0x00000080.
- Misaligned word store/load:
  - Store 0x12345678 at 0x56 → beat0: `d_addr` 0x15, `d_be` 1100, `d_wdata` 0x56780000; beat1: `d_addr` 0x16, `d_be` 0011, `d_wdata` 0x00001234; ack at T+3.
  - Word load at 0x56 → 0x12345678 at T+4.
- Halfword at 0x60: store 0xFFFB → `d_be` 0011. Signed load → 0xFFFFFFFB; unsigned → 0x0000FFFB.
- Boundary cases:
  - Halfword store at 0xFFFFFFFF → beats at `d_addr` 0x3FFFFFFF (`d_be` 1000) then 0x00000000 (`d_be` 0001).
  - Width 11 → `resp_err` 1 at T+1, `d_we` never asserted.
- Reset asserted during BEAT1 of a misaligned store → `d_we` / `d_be` drop asynchronously, no `resp_valid`. After release `req_ready` = 1 and the next request completes normally.
- Back-to-back requests with `req_valid` held high: requests are accepted only in IDLE, the second in the cycle after RESP. Each produces exactly one `resp_valid` pulse.
